anim_sprite_bitmap: RTL and testbench
=====================================

ANIM_SPRITE_BITMAP -- requirements
Module: anim_sprite_bitmap

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- OBJECT_X_BITS, 5: sprite width = 2^OBJECT_X_BITS.
- OBJECT_Y_BITS, 5: sprite height = 2^OBJECT_Y_BITS.
- NUM_FRAMES, 4: animation frames, >=1.
- FRAME_HOLD, 4: video frames per animation step, >=1.
- LOOP, 1: 1 = wrap to frame 0; 0 = one-shot.
- TRANSPARENT_ENCODING, 8'hFF: transparent colour.
- MEM_INIT_FILE, "": frame ROM image; empty selects the built-in test pattern.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- resetN, in, 1: reset, asynchronous, active-low.
- pixelX, in, 11: X offset from the sprite's top-left corner.
- pixelY, in, 11: Y offset from the sprite's top-left corner.
- objectExists, in, 1: pixel is inside the sprite bracket.
- startOfFrame, in, 1: one-cycle pulse per video frame.
- animStart, in, 1: pulse; start or restart the animation.
- animStop, in, 1: pulse; return to IDLE.
- mirrorX, in, 1: draw the sprite horizontally flipped.
- drawingRequest, out, 1: pixel is to be displayed.
- RGBout, out, 8: RGB332 colour.
- HitEdgeCode, out, 4: {Left, Top, Right, Bottom}.
- frameIndex, out, max(1,clog2(NUM_FRAMES)): current frame.
- animBusy, out, 1: high in RUN.
- animDone, out, 1: one-cycle pulse on one-shot completion.

REQ-003 The design SHALL use the single clock clk; resetN SHALL be asynchronous and active-low.

Function
REQ-004 Built-in pattern: the colour at (frame f, row y, col x) SHALL be {f[1:0], y[2:0], x[2:0]}.
REQ-005 Effective column SHALL be xe = 2^OBJECT_X_BITS-1-pixelX when mirrorX=1, and pixelX otherwise. Row SHALL be pixelY.
REQ-006 RGBout SHALL be registered with 1-cycle latency:
- ROM[frameIndex][pixelY][xe] when objectExists=1, pixelX < width and pixelY < height.
- TRANSPARENT_ENCODING otherwise.
REQ-007 drawingRequest SHALL be combinational: high when RGBout != TRANSPARENT_ENCODING.
REQ-008 HitEdgeCode SHALL be registered alongside RGBout, using a 4x4 collision grid:
- col = xe >> (OBJECT_X_BITS-2); row = pixelY >> (OBJECT_Y_BITS-2).
- Left = (col==0), Right = (col==3), Top = (row==0), Bottom = (row==3).
- 4'b0000 whenever RGBout is forced transparent.
REQ-009 States SHALL be IDLE, RUN and DONE.
- IDLE: frameIndex=0, hold counter=0.
- RUN: each startOfFrame increments the hold counter; at FRAME_HOLD-1 the counter clears and the frame advances.
- DONE: frameIndex=NUM_FRAMES-1, held until animStart or animStop.
REQ-010 Frame advance in RUN from frameIndex NUM_FRAMES-1:
- LOOP=1: frameIndex SHALL wrap to 0 and the state SHALL stay RUN.
- LOOP=0: the state SHALL go to DONE, frameIndex SHALL stay NUM_FRAMES-1, and animDone SHALL pulse for exactly one cycle.
REQ-011 animStart in any state SHALL enter RUN with frameIndex=0 and hold counter=0 on the next edge.
REQ-012 animStop in any state SHALL enter IDLE on the next edge.
REQ-013 Priority SHALL be animStop > animStart > startOfFrame; an overridden startOfFrame SHALL be ignored.
REQ-014 frameIndex SHALL change only at clock edges. A pixel sampled in the same cycle as a frame advance SHALL use the old frameIndex.
REQ-015 animBusy SHALL equal (state==RUN).
REQ-016 When NUM_FRAMES=1, frameIndex SHALL be constant 0. With LOOP=0, DONE SHALL be entered after FRAME_HOLD startOfFrame pulses.

Reset
REQ-017 While resetN=0, the outputs SHALL be:
- RGBout = TRANSPARENT_ENCODING, so drawingRequest = 0.
- HitEdgeCode = 0, frameIndex = 0.
- animBusy = 0, animDone = 0.
- state = IDLE, hold counter = 0.
REQ-018 Reset asserted mid-RUN SHALL abort the animation immediately. After release the block SHALL stay in IDLE until animStart.

Verification (defaults, built-in pattern)
REQ-019 Reset: assert resetN=0 mid-RUN -> RGBout=8'hFF, drawingRequest=0, frameIndex=0, animBusy=0 in the same cycle.
REQ-020 Static pixel: IDLE, objectExists=1, pixelX=5, pixelY=3 -> next cycle RGBout=8'h1D, drawingRequest=1, HitEdgeCode=4'b1100.
REQ-021 Mirror: same pixel with mirrorX=1 -> RGBout=8'h1A, HitEdgeCode=4'b0110. Then pixelX=32 -> RGBout=8'hFF, HitEdgeCode=0.
REQ-022 Loop: animStart, then startOfFrame pulses:
- after 4 pulses frameIndex=1.
- after 16 pulses frameIndex=0 and animBusy=1.
- frame 3, pixel (7,7) -> drawingRequest=0.
REQ-023 One-shot (LOOP=0): animStart, then startOfFrame pulses:
- after 12 pulses frameIndex=3.
- after 16 pulses the state is DONE, animDone is high for exactly 1 cycle and animBusy=0.
- further pulses leave frameIndex=3.
REQ-024 Priority:
- animStart and animStop in the same cycle -> IDLE, frameIndex=0.
- animStart together with the 4th startOfFrame -> frameIndex=0, hold counter=0.

Source files
------------

// File: rtl/anim_sprite_bitmap.sv
// Animated sprite bitmap: per-pixel frame ROM lookup with mirroring, a 4x4 hit-edge grid,
// and an IDLE/RUN/DONE animation sequencer stepped by startOfFrame.
module anim_sprite_bitmap #(
  parameter int         OBJECT_X_BITS        = 5,
  parameter int         OBJECT_Y_BITS        = 5,
  parameter int         NUM_FRAMES           = 4,
  parameter int         FRAME_HOLD           = 4,
  parameter int         LOOP                 = 1,
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter             MEM_INIT_FILE        = "",
  localparam int        FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [10:0]   pixelX,
  input  logic [10:0]   pixelY,
  input  logic          objectExists,
  input  logic          startOfFrame,
  input  logic          animStart,
  input  logic          animStop,
  input  logic          mirrorX,
  output logic          drawingRequest,
  output logic [7:0]    RGBout,
  output logic [3:0]    HitEdgeCode,
  output logic [FW-1:0] frameIndex,
  output logic          animBusy,
  output logic          animDone
);

  localparam int W  = 1 << OBJECT_X_BITS;
  localparam int H  = 1 << OBJECT_Y_BITS;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [7:0] rgb;
    logic [3:0] hit;
  } pix_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   frame_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            done_q, done_nxt;

  // ---------------- animation sequencer ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      frameIndex <= '0;
      hold_cnt   <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      frameIndex <= frame_nxt;
      hold_cnt   <= hold_nxt;
      done_q     <= done_nxt;
    end
  end

  // animStop beats animStart, which beats startOfFrame
  always_comb begin
    state_nxt = state;
    frame_nxt = frameIndex;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    if (animStop) begin
      state_nxt = IDLE;
      frame_nxt = '0;
      hold_nxt  = '0;
    end else if (animStart) begin
      state_nxt = RUN;
      frame_nxt = '0;
      hold_nxt  = '0;
    end else if (state == RUN && startOfFrame) begin
      if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
        hold_nxt = '0;
        if (frameIndex == FW'(NUM_FRAMES - 1)) begin
          if (LOOP != 0) begin
            frame_nxt = '0;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          frame_nxt = frameIndex + FW'(1);
        end
      end else begin
        hold_nxt = hold_cnt + HW'(1);
      end
    end
  end

  always_comb begin
    animBusy = (state == RUN);
    animDone = done_q;
  end

  // ---------------- pixel path ----------------
  logic                     in_range;
  logic [OBJECT_X_BITS-1:0] xe;
  logic [OBJECT_Y_BITS-1:0] yr;
  logic [7:0]               rom_pix;
  logic [1:0]               col, row;
  pix_t                     pix_d, pix_q;

  // For in-range columns W-1-x is the bitwise complement of x
  assign xe       = pixelX[OBJECT_X_BITS-1:0] ^ {OBJECT_X_BITS{mirrorX}};
  assign yr       = pixelY[OBJECT_Y_BITS-1:0];
  assign in_range = objectExists && (int'(pixelX) < W) && (int'(pixelY) < H);
  assign col      = xe[OBJECT_X_BITS-1 -: 2];
  assign row      = yr[OBJECT_Y_BITS-1 -: 2];

  generate
    if (MEM_INIT_FILE == "") begin : g_pattern
      logic [1:0] f2;
      logic [2:0] y3, x3;
      assign f2      = 2'(frameIndex);
      assign y3      = 3'(yr);
      assign x3      = 3'(xe);
      assign rom_pix = {f2, y3, x3};
    end else begin : g_rom
      (* ram_init_file = MEM_INIT_FILE *) logic [7:0] rom [NUM_FRAMES*W*H];
      assign rom_pix = rom[(int'(frameIndex) * H + int'(yr)) * W + int'(xe)];
    end
  endgenerate

  always_comb begin
    pix_d.rgb = TRANSPARENT_ENCODING;
    pix_d.hit = 4'b0000;
    if (in_range) begin
      pix_d.rgb = rom_pix;
      pix_d.hit = {col == 2'd0, row == 2'd0, col == 2'd3, row == 2'd3};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_q.rgb <= TRANSPARENT_ENCODING;
      pix_q.hit <= 4'b0000;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign RGBout         = pix_q.rgb;
  assign HitEdgeCode    = pix_q.hit;
  assign drawingRequest = (pix_q.rgb != TRANSPARENT_ENCODING);

endmodule

// File: tb/tb_anim_sprite_bitmap.sv
// Directed bench for anim_sprite_bitmap: a looping and a one-shot instance share stimulus.
module tb_anim_sprite_bitmap;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        objectExists, startOfFrame, animStart, animStop, mirrorX;

  logic       dr0, dr1, busy0, busy1, done0, done1;
  logic [7:0] rgb0, rgb1;
  logic [3:0] hit0, hit1;
  logic [1:0] frame0, frame1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  anim_sprite_bitmap dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .objectExists(objectExists), .startOfFrame(startOfFrame), .animStart(animStart),
    .animStop(animStop), .mirrorX(mirrorX), .drawingRequest(dr0), .RGBout(rgb0),
    .HitEdgeCode(hit0), .frameIndex(frame0), .animBusy(busy0), .animDone(done0)
  );

  anim_sprite_bitmap #(.LOOP(0)) dut1 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .objectExists(objectExists), .startOfFrame(startOfFrame), .animStart(animStart),
    .animStop(animStop), .mirrorX(mirrorX), .drawingRequest(dr1), .RGBout(rgb1),
    .HitEdgeCode(hit1), .frameIndex(frame1), .animBusy(busy1), .animDone(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic start_pulse();
    animStart = 1'b1;
    tick();
    animStart = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input logic m, input logic oe);
    pixelX       = 11'(x);
    pixelY       = 11'(y);
    mirrorX      = m;
    objectExists = oe;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    set_pix(5, 3, 1'b0, 1'b1);
    tick(); tick();
    n_cmp++; if (rgb0 !== 8'hFF) begin n_err++; $display("FAIL reset_rgb: got %h want ff", rgb0); end
    n_cmp++; if (dr0 !== 1'b0) begin n_err++; $display("FAIL reset_dr: got %b want 0", dr0); end
    n_cmp++; if (hit0 !== 4'b0000) begin n_err++; $display("FAIL reset_hit: got %b want 0000", hit0); end
    n_cmp++; if (frame0 !== 2'd0) begin n_err++; $display("FAIL reset_frame: got %0d want 0", frame0); end
    n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy0, done0); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_static();
    set_pix(5, 3, 1'b0, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'h1D) begin n_err++; $display("FAIL static_rgb: got %h want 1d", rgb0); end
    n_cmp++; if (dr0 !== 1'b1) begin n_err++; $display("FAIL static_dr: got %b want 1", dr0); end
    n_cmp++; if (hit0 !== 4'b1100) begin n_err++; $display("FAIL static_hit: got %b want 1100", hit0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL static_idle: got busy %b want 0", busy0); end
  endtask

  task automatic test_mirror();
    set_pix(5, 3, 1'b1, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'h1A) begin n_err++; $display("FAIL mirror_rgb: got %h want 1a", rgb0); end
    n_cmp++; if (hit0 !== 4'b0110) begin n_err++; $display("FAIL mirror_hit: got %b want 0110", hit0); end
    set_pix(32, 3, 1'b1, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'hFF) begin n_err++; $display("FAIL mirror_x32_rgb: got %h want ff", rgb0); end
    n_cmp++; if (hit0 !== 4'b0000) begin n_err++; $display("FAIL mirror_x32_hit: got %b want 0000", hit0); end
    n_cmp++; if (dr0 !== 1'b0) begin n_err++; $display("FAIL mirror_x32_dr: got %b want 0", dr0); end
    set_pix(31, 31, 1'b0, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'h3F || hit0 !== 4'b0011) begin n_err++; $display("FAIL corner: got %h/%b want 3f/0011", rgb0, hit0); end
    set_pix(5, 3, 1'b0, 1'b0);
    tick();
    n_cmp++; if (rgb0 !== 8'hFF || hit0 !== 4'b0000) begin n_err++; $display("FAIL no_object: got %h/%b want ff/0000", rgb0, hit0); end
  endtask

  task automatic test_loop();
    start_pulse();
    n_cmp++; if (busy0 !== 1'b1 || frame0 !== 2'd0) begin n_err++; $display("FAIL loop_start: got busy %b frame %0d want 1/0", busy0, frame0); end
    sof(3);
    n_cmp++; if (frame0 !== 2'd0) begin n_err++; $display("FAIL loop_3sof: got %0d want 0", frame0); end
    set_pix(5, 3, 1'b0, 1'b1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    n_cmp++; if (rgb0 !== 8'h1D) begin n_err++; $display("FAIL loop_old_frame_rgb: got %h want 1d", rgb0); end
    n_cmp++; if (frame0 !== 2'd1) begin n_err++; $display("FAIL loop_4sof: got %0d want 1", frame0); end
    tick();
    n_cmp++; if (rgb0 !== 8'h5D) begin n_err++; $display("FAIL loop_frame1_rgb: got %h want 5d", rgb0); end
    sof(8);
    n_cmp++; if (frame0 !== 2'd3) begin n_err++; $display("FAIL loop_12sof: got %0d want 3", frame0); end
    set_pix(7, 7, 1'b0, 1'b1);
    tick();
    n_cmp++; if (dr0 !== 1'b0 || rgb0 !== 8'hFF) begin n_err++; $display("FAIL loop_f3_77: got dr %b rgb %h want 0/ff", dr0, rgb0); end
    set_pix(5, 3, 1'b0, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'hDD) begin n_err++; $display("FAIL loop_f3_rgb: got %h want dd", rgb0); end
    sof(4);
    n_cmp++; if (frame0 !== 2'd0 || busy0 !== 1'b1) begin n_err++; $display("FAIL loop_wrap: got frame %0d busy %b want 0/1", frame0, busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL loop_no_done: got %b want 0", done0); end
  endtask

  task automatic test_oneshot();
    int extra;
    start_pulse();
    sof(12);
    n_cmp++; if (frame1 !== 2'd3 || busy1 !== 1'b1) begin n_err++; $display("FAIL os_12sof: got frame %0d busy %b want 3/1", frame1, busy1); end
    sof(3);
    n_cmp++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_err++; $display("FAIL os_15sof: got busy %b done %b want 1/0", busy1, done1); end
    sof(1);
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL os_done_pulse: got %b want 1", done1); end
    n_cmp++; if (busy1 !== 1'b0 || frame1 !== 2'd3) begin n_err++; $display("FAIL os_done_state: got busy %b frame %0d want 0/3", busy1, frame1); end
    tick();
    n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL os_done_width: got %b want 0", done1); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (done1 !== 1'b0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL os_extra_done: got %0d pulses want 0", extra); end
    n_cmp++; if (frame1 !== 2'd3 || busy1 !== 1'b0) begin n_err++; $display("FAIL os_hold: got frame %0d busy %b want 3/0", frame1, busy1); end
    n_cmp++; if (frame0 !== 2'd1 || busy0 !== 1'b1) begin n_err++; $display("FAIL os_loop_ref: got frame %0d busy %b want 1/1", frame0, busy0); end
    animStop = 1'b1;
    tick();
    animStop = 1'b0;
    n_cmp++; if (frame1 !== 2'd0 || busy1 !== 1'b0 || frame0 !== 2'd0) begin n_err++; $display("FAIL os_stop: got f1 %0d b1 %b f0 %0d want 0/0/0", frame1, busy1, frame0); end
  endtask

  task automatic test_priority();
    start_pulse();
    sof(4);
    n_cmp++; if (frame0 !== 2'd1) begin n_err++; $display("FAIL prio_setup: got %0d want 1", frame0); end
    animStart = 1'b1;
    animStop  = 1'b1;
    tick();
    animStart = 1'b0;
    animStop  = 1'b0;
    n_cmp++; if (busy0 !== 1'b0 || frame0 !== 2'd0) begin n_err++; $display("FAIL prio_stop_start: got busy %b frame %0d want 0/0", busy0, frame0); end
    start_pulse();
    sof(3);
    animStart    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    animStart    = 1'b0;
    startOfFrame = 1'b0;
    n_cmp++; if (frame0 !== 2'd0 || busy0 !== 1'b1) begin n_err++; $display("FAIL prio_start_sof: got frame %0d busy %b want 0/1", frame0, busy0); end
    sof(3);
    n_cmp++; if (frame0 !== 2'd0) begin n_err++; $display("FAIL prio_hold_cleared: got %0d want 0", frame0); end
    sof(1);
    n_cmp++; if (frame0 !== 2'd1) begin n_err++; $display("FAIL prio_advance: got %0d want 1", frame0); end
    animStop     = 1'b1;
    startOfFrame = 1'b1;
    tick();
    animStop     = 1'b0;
    startOfFrame = 1'b0;
    n_cmp++; if (busy0 !== 1'b0 || frame0 !== 2'd0) begin n_err++; $display("FAIL prio_stop_sof: got busy %b frame %0d want 0/0", busy0, frame0); end
  endtask

  task automatic test_reset_mid_run();
    start_pulse();
    sof(5);
    set_pix(5, 3, 1'b0, 1'b1);
    tick();
    n_cmp++; if (rgb0 !== 8'h5D || busy0 !== 1'b1) begin n_err++; $display("FAIL mid_setup: got rgb %h busy %b want 5d/1", rgb0, busy0); end
    resetN = 1'b0;
    #1;
    n_cmp++; if (rgb0 !== 8'hFF || dr0 !== 1'b0) begin n_err++; $display("FAIL mid_reset_pix: got rgb %h dr %b want ff/0", rgb0, dr0); end
    n_cmp++; if (frame0 !== 2'd0 || busy0 !== 1'b0) begin n_err++; $display("FAIL mid_reset_anim: got frame %0d busy %b want 0/0", frame0, busy0); end
    tick();
    resetN = 1'b1;
    sof(6);
    n_cmp++; if (busy0 !== 1'b0 || frame0 !== 2'd0) begin n_err++; $display("FAIL post_reset_idle: got busy %b frame %0d want 0/0", busy0, frame0); end
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    animStart = 1'b0;
    animStop = 1'b0;
    set_pix(0, 0, 1'b0, 1'b0);
    test_reset();
    test_static();
    test_mirror();
    test_loop();
    test_oneshot();
    test_priority();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
